reg_write_arbiter: RTL
======================

Name: reg_write_arbiter

Overview:
- Shares one bank of NREGS 8-bit enable-load registers between two write requesters.
- Arbitrates between the requesters (round-robin), latches the winner's address and data, then drives a one-hot register enable and the shared data-in bus for exactly one cycle.
- Sits in front of the register bank; each register's EN comes from reg_en[i], and every register's data input is tied to reg_din.

Parameters:
- DATA_W, 8, width of register data.
- ADDR_W, 2, width of the requester address.
- NREGS, 4, number of registers in the bank; must satisfy 1 <= NREGS <= 2**ADDR_W.

Ports:
- clk  input  1  system clock; rising-edge.
- res  input  1  reset; asynchronous, active-low.
- req0  input  1  requester 0 write request.
- addr0  input  ADDR_W  requester 0 target register index.
- data0  input  DATA_W  requester 0 write data.
- gnt0  output  1  requester 0 grant pulse.
- req1  input  1  requester 1 write request.
- addr1  input  ADDR_W  requester 1 target register index.
- data1  input  DATA_W  requester 1 write data.
- gnt1  output  1  requester 1 grant pulse.
- reg_en  output  NREGS  one-hot register load enables.
- reg_din  output  DATA_W  shared register data bus.
- busy  output  1  high while in WRITE.
- err  output  1  pulse: granted address >= NREGS.

Behaviour:
- Reset (res=0, async): state=IDLE; gnt0=gnt1=0; reg_en=0; reg_din=0; busy=0; err=0; last-grant pointer=1, so requester 0 wins the first tie.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE and WRITE.
- IDLE, no req: stay in IDLE; all pulses stay 0; reg_din holds its last value.
- IDLE, any req sampled high at a clk edge:
  - Select the winner and latch its addr/data.
  - Go to WRITE.
  - Update the pointer to the winner.
- Winner selection:
  - Only one req high: that requester wins.
  - Both high: the requester not equal to the pointer wins (alternation).
- WRITE (exactly 1 cycle):
  - gnt of the winner = 1; busy = 1; reg_din = latched data.
  - reg_en[latched addr] = 1, all other bits 0.
  - The target register loads on the edge ending WRITE.
  - Next state: always IDLE.
- Latency: req sampled at edge N, then WRITE during cycle N..N+1, then the register holds the new data after edge N+1.
- Throughput: at most one write per 2 cycles.
- Handshake: a requester holds req, addr and data stable until it sees gnt=1, then drops req at the edge ending WRITE.
  - If req stays high in the following IDLE cycle, it is treated as a new request.
  - addr/data changes before gnt are legal; the value latched at the arbitration edge is written.
- Out-of-range address (addr >= NREGS):
  - Grant is still issued and busy=1.
  - reg_en stays all-zero (write dropped).
  - err=1 for the WRITE cycle.
- The loser of a tie keeps requesting and is granted on the next arbitration (2 cycles later), so there is no starvation.
- Reset asserted during WRITE: reg_en, gnt and busy clear immediately (asynchronously); no partial write is guaranteed.
- reg_en is never multi-hot; gnt0 and gnt1 are never both 1.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both requesters are high; the pointer is unused and need not be implemented; requester 1 can be starved.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset: hold res=0, pulse clk -> gnt0=gnt1=0, reg_en=4'b0000, reg_din=8'h00, busy=0, err=0; release res -> stay IDLE with no req.
- Single write: req0=1, addr0=2, data0=8'hA5 for one edge -> next cycle gnt0=1, reg_en=4'b0100, reg_din=8'hA5, busy=1; following cycle all pulses 0.
- Tie/round-robin: from reset, req0=req1=1 held continuously, addr0=0/data0=8'h11, addr1=3/data1=8'h22:
  - first WRITE: gnt0, reg_en=0001, 8'h11;
  - second WRITE: gnt1, reg_en=1000, 8'h22;
  - third WRITE: gnt0 again.
  - With ARB_FIXED_PRIO_EN defined, all three grants go to gnt0.
- Out-of-range: NREGS=3, req1=1, addr1=3, data1=8'hFF -> gnt1=1, err=1, reg_en=3'b000; the bank is unchanged.
- Reset mid-write: assert res=0 halfway through the WRITE cycle -> reg_en, gnt0 and busy go 0 before the next clk edge; state is IDLE after release.
- Back-to-back: req0 held high for 6 cycles -> gnt0 pulses every 2nd cycle (3 grants); busy alternates 1/0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Two-requester write arbiter in front of an NREGS x DATA_W enable-load register bank.
// Round-robin by default; define ARB_FIXED_PRIO_EN to make requester 0 always win ties.
module reg_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int NREGS  = 4
) (
    input  logic              clk,
    input  logic              res,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt1,
    output logic [NREGS-1:0]  reg_en,
    output logic [DATA_W-1:0] reg_din,
    output logic              busy,
    output logic              err
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_arb;
    logic              w_pick1;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [NREGS-1:0]  w_en_dec;
    logic              w_oor;

`ifdef ARB_FIXED_PRIO_EN
    assign w_pick1 = req1 & ~req0;
`else
    // r_ptr remembers the last winner; on a tie the other requester goes next.
    logic r_ptr;

    assign w_pick1 = req1 & (~req0 | ~r_ptr);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_ptr <= 1'b1;
        end else if (w_arb) begin
            r_ptr <= w_pick1;
        end
    end
`endif

    assign w_arb  = (r_state == S_IDLE) & (req0 | req1);
    assign w_addr = w_pick1 ? addr1 : addr0;
    assign w_data = w_pick1 ? data1 : data0;
    assign w_oor  = (int'(w_addr) >= NREGS);

    always_comb begin
        w_en_dec = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (int'(w_addr) == i) begin
                w_en_dec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_arb) w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are loaded at the arbitration edge so they are valid for the whole WRITE cycle.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            reg_en  <= '0;
            reg_din <= '0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            gnt0   <= w_arb & ~w_pick1;
            gnt1   <= w_arb & w_pick1;
            busy   <= w_arb;
            err    <= w_arb & w_oor;
            reg_en <= w_arb ? w_en_dec : '0;
            if (w_arb) begin
                reg_din <= w_data;
            end
        end
    end

endmodule
